// File: rtl/ripemd160_core_arbiter.sv
// ---------------------------------------------------------------------------
// ripemd160_core_arbiter
//
// Shares one RIPEMD-160 round core between two block requesters. One 512-bit
// block is accepted at a time (round-robin when both requesters are valid).
// The block is issued to the core with a single-cycle start pulse. The arbiter
// then waits for completion under a watchdog and returns the 160-bit result
// tagged with the owning requester.
//
// Parameters
//   TIMEOUT       cycles allowed in WAIT before the job is aborted (4..255)
//
// Ports
//   clk_p_i       clock, posedge
//   rst_n         asynchronous active-low reset
//   req_valid_i   [1:0]    per-requester block valid (bit k = requester k)
//   req_block_i   [1023:0] [511:0] requester 0, [1023:512] requester 1
//   req_ready_o   [1:0]    one-hot accept strobe, combinational, IDLE only
//   core_valid_o           one-cycle start pulse to the core
//   core_block_o  [511:0]  block presented to the core
//   core_done_i            core completion, sampled only in WAIT
//   core_ans_i    [159:0]  core result, valid with core_done_i
//   resp_valid_o           result available
//   resp_id_o              requester that owns the result
//   resp_ans_o    [159:0]  hash result (zero on watchdog abort)
//   resp_err_o             watchdog expired
//   resp_ready_i           consumer accepts the result
//   busy_o                 high in every state except IDLE
// ---------------------------------------------------------------------------
module ripemd160_core_arbiter #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic           clk_p_i,
  input  logic           rst_n,
  input  logic [1:0]     req_valid_i,
  input  logic [1023:0]  req_block_i,
  output logic [1:0]     req_ready_o,
  output logic           core_valid_o,
  output logic [511:0]   core_block_o,
  input  logic           core_done_i,
  input  logic [159:0]   core_ans_i,
  output logic           resp_valid_o,
  output logic           resp_id_o,
  output logic [159:0]   resp_ans_o,
  output logic           resp_err_o,
  input  logic           resp_ready_i,
  output logic           busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Last count value reached before the watchdog fires.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic           prio_q,  prio_d;
  logic           id_q,    id_d;
  logic [7:0]     cnt_q,   cnt_d;
  logic [511:0]   blk_q,   blk_d;
  logic [159:0]   ans_q,   ans_d;
  logic           err_q,   err_d;

  logic           grant_id;

  always_ff @(posedge clk_p_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= 8'd0;
      blk_q   <= '0;
      ans_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      ans_q   <= ans_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    ans_d       = ans_q;
    err_d       = err_q;
    req_ready_o = 2'b00;

    // With both valid the rotating priority decides; otherwise the single
    // valid requester wins (bit 1 alone selects requester 1).
    if (req_valid_i == 2'b11) begin
      grant_id = prio_q;
    end else begin
      grant_id = req_valid_i[1];
    end

    case (state_q)
      ST_IDLE: begin
        // Ready is only raised towards a valid requester, so a raised
        // ready is itself the handshake. Gated by rst_n so the strobe is
        // silent while reset is held.
        if ((req_valid_i != 2'b00) && rst_n) begin
          req_ready_o = grant_id ? 2'b10 : 2'b01;
          blk_d       = grant_id ? req_block_i[1023:512] : req_block_i[511:0];
          id_d        = grant_id;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion beats the watchdog when both land in the same cycle.
        if (core_done_i) begin
          ans_d   = core_ans_i;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          ans_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready_i) begin
          prio_d  = ~id_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Everything below is decoded from registers only.
  assign core_valid_o = (state_q == ST_ISSUE);
  assign core_block_o = blk_q;
  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_id_o    = id_q;
  assign resp_ans_o   = ans_q;
  assign resp_err_o   = err_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ripemd160_core_arbiter.sv
module tb_ripemd160_core_arbiter;

  localparam int TIMEOUT = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     req_valid_i;
  logic [1023:0]  req_block_i;
  logic [1:0]     req_ready_o;
  logic           core_valid_o;
  logic [511:0]   core_block_o;
  logic           core_done_i = 1'b0;
  logic [159:0]   core_ans_i  = '0;
  logic           resp_valid_o;
  logic           resp_id_o;
  logic [159:0]   resp_ans_o;
  logic           resp_err_o;
  logic           resp_ready_i;
  logic           busy_o;

  ripemd160_core_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk_p_i      (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_block_i  (req_block_i),
    .req_ready_o  (req_ready_o),
    .core_valid_o (core_valid_o),
    .core_block_o (core_block_o),
    .core_done_i  (core_done_i),
    .core_ans_i   (core_ans_i),
    .resp_valid_o (resp_valid_o),
    .resp_id_o    (resp_id_o),
    .resp_ans_o   (resp_ans_o),
    .resp_err_o   (resp_err_o),
    .resp_ready_i (resp_ready_i),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Core model knobs, written by the stimulus process.
  int           core_delay = 18;   // 0 = never completes
  logic [159:0] core_ans_v = '0;
  logic         force_done = 1'b0;

  // Core model: done is high exactly core_delay cycles after the start pulse.
  int   rem = 0;
  logic done_m;
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      rem         = 0;
      core_done_i = 1'b0;
    end else begin
      done_m = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) done_m = 1'b1;
      end
      if (core_valid_o) rem = core_delay;
      core_done_i = done_m | force_done;
    end
    core_ans_i = core_ans_v;
  end

  // Scoreboard
  typedef struct {
    logic         id;
    logic [159:0] ans;
    logic         err;
    int           acc;
    int           rise;
    logic [511:0] blk;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  exp_t nxt;
  int   cyc           = 0;
  int   accepted_jobs = 0;
  int   done_jobs     = 0;
  logic in_flight     = 1'b0;
  logic prio_m        = 1'b0;
  logic gid;
  logic [1:0] exp_ready;
  logic exp_cv;
  logic exp_rv;

  always @(posedge clk) begin
    #6;
    cyc++;
    if (!rst_n) begin
      sb_q.delete();
      in_flight = 1'b0;
      prio_m    = 1'b0;
    end else begin
      gid       = (req_valid_i == 2'b11) ? prio_m : req_valid_i[1];
      exp_ready = (!in_flight && req_valid_i != 2'b00) ? (gid ? 2'b10 : 2'b01) : 2'b00;
      check_val("req_ready", req_ready_o, exp_ready);
      check_val("busy", busy_o, in_flight);
      if (in_flight) begin
        cur    = sb_q[0];
        exp_cv = (cyc == cur.acc + 1);
        exp_rv = (cyc >= cur.rise);
        check_val("core_valid", core_valid_o, exp_cv);
        if (exp_cv) check_val("core_block", core_block_o, cur.blk);
        check_val("resp_valid", resp_valid_o, exp_rv);
        if (exp_rv) begin
          check_val("resp_id", resp_id_o, cur.id);
          check_val("resp_err", resp_err_o, cur.err);
          check_val("resp_ans", resp_ans_o, cur.ans);
          if (resp_ready_i) begin
            $display("job %0d: id=%0d err=%0d ans=%h accepted@%0d resp@%0d",
                     done_jobs, cur.id, cur.err, cur.ans, cur.acc, cur.rise);
            prio_m = ~cur.id;
            void'(sb_q.pop_front());
            in_flight = 1'b0;
            done_jobs++;
          end
        end
      end else begin
        check_val("core_valid_idle", core_valid_o, 1'b0);
        check_val("resp_valid_idle", resp_valid_o, 1'b0);
      end
      if ((exp_ready & req_valid_i) != 2'b00) begin
        nxt.id   = gid;
        nxt.blk  = gid ? req_block_i[1023:512] : req_block_i[511:0];
        nxt.err  = (core_delay == 0) || (core_delay > TIMEOUT);
        nxt.ans  = nxt.err ? 160'd0 : core_ans_v;
        nxt.acc  = cyc;
        nxt.rise = cyc + (nxt.err ? TIMEOUT + 2 : core_delay + 2);
        sb_q.push_back(nxt);
        in_flight = 1'b1;
        accepted_jobs++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accepted(input int target, input string tag);
    int n = 0;
    while (accepted_jobs < target && n < 200) begin step(); n++; end
    check_val(tag, accepted_jobs, target);
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_jobs < target && n < 400) begin step(); n++; end
    check_val(tag, done_jobs, target);
  endtask

  task automatic wait_resp_valid(input string tag);
    int n = 0;
    while (!resp_valid_o && n < 100) begin step(); n++; end
    check_val(tag, resp_valid_o, 1'b1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_req_ready"},  req_ready_o,  2'b00);
    check_val({pfx, "_core_valid"}, core_valid_o, 1'b0);
    check_val({pfx, "_core_block"}, core_block_o, 512'd0);
    check_val({pfx, "_resp_valid"}, resp_valid_o, 1'b0);
    check_val({pfx, "_resp_id"},    resp_id_o,    1'b0);
    check_val({pfx, "_resp_ans"},   resp_ans_o,   160'd0);
    check_val({pfx, "_resp_err"},   resp_err_o,   1'b0);
    check_val({pfx, "_busy"},       busy_o,       1'b0);
  endtask

  task automatic rand_blocks();
    for (int i = 0; i < 32; i++) req_block_i[i*32 +: 32] = $urandom;
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid_i  = 2'b00;
    req_block_i  = '0;
    resp_ready_i = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // Simultaneous requests, four back-to-back jobs: ids 0,1,0,1.
    core_delay = 18;
    core_ans_v = 160'h0123456789abcdef0123456789abcdef01234567;
    rand_blocks();
    req_valid_i = 2'b11;
    wait_done(4, "rr_done");
    req_valid_i = 2'b00;
    step();

    // Single job from requester 0.
    req_block_i = '0;
    req_block_i[31:0] = 32'h0000_0080;
    core_ans_v  = 160'h9c1185a5c5e9fc54612808977ee8f548b2258d31;
    req_valid_i = 2'b01;
    wait_accepted(5, "single_acc");
    req_valid_i = 2'b00;
    wait_done(5, "single_done");

    // Backpressure, with requester 1 waiting the whole time.
    rand_blocks();
    core_ans_v   = 160'hfeedface00112233445566778899aabbccddeeff;
    resp_ready_i = 1'b0;
    req_valid_i  = 2'b01;
    wait_accepted(6, "bp_acc");
    req_valid_i  = 2'b10;
    wait_resp_valid("bp_resp");
    repeat (10) step();
    // Next accepted job (requester 1) is the watchdog job.
    core_delay   = 0;
    core_ans_v   = 160'hdeadbeefdeadbeefdeadbeefdeadbeefdeadbeef;
    resp_ready_i = 1'b1;
    wait_done(6, "bp_done");

    // Watchdog: no done, then a late done while the response is held.
    wait_accepted(7, "wd_acc");
    req_valid_i  = 2'b00;
    resp_ready_i = 1'b0;
    wait_resp_valid("wd_resp");
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    repeat (2) step();
    resp_ready_i = 1'b1;
    wait_done(7, "wd_done");

    // Done exactly on the watchdog expiry cycle.
    core_delay  = TIMEOUT;
    core_ans_v  = 160'h13579bdf2468ace013579bdf2468ace013579bdf;
    rand_blocks();
    req_valid_i = 2'b01;
    wait_accepted(8, "exp_acc");
    req_valid_i = 2'b00;
    wait_done(8, "exp_done");

    // Reset in WAIT (cycle 8 after accept); prio must return to 0.
    core_delay  = 18;
    core_ans_v  = 160'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;
    rand_blocks();
    req_valid_i = 2'b01;
    wait_accepted(9, "rst_acc");
    req_valid_i = 2'b00;
    repeat (7) step();
    req_valid_i = 2'b11;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    step();
    rst_n = 1'b1;
    wait_accepted(10, "post_rst_acc");
    req_valid_i = 2'b00;
    wait_done(9, "post_rst_done");
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
